// File: rtl/mmio_fifo_ctrl_pkg.sv
// Shared constants and types for the MMIO-to-shift-FIFO sequencing controller.
package mmio_fifo_ctrl_pkg;

  localparam logic [15:0] MMIO_DATA_ADDR = 16'h0020;
  localparam logic [15:0] MMIO_STAT_ADDR = 16'h0022;
  localparam logic [15:0] MMIO_CTRL_ADDR = 16'h0024;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } t_fifo_ctrl_state;

  // Status word bit positions
  localparam int unsigned STAT_FULL_BIT     = 0;
  localparam int unsigned STAT_FLUSHING_BIT = 1;
  localparam int unsigned STAT_DROP_BIT     = 2;
  localparam int unsigned STAT_OVWR_BIT     = 3;
  localparam int unsigned STAT_CNT_LSB      = 8;

  // Control register bit positions
  localparam int unsigned FLUSH_BIT = 0;
  localparam int unsigned CLR_BIT   = 1;

endpackage

// File: rtl/mmio_fifo_ctrl.sv
// Turns MMIO writes into shift-FIFO pushes, runs the flush sequence and
// returns single-cycle read responses for data, status and control registers.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | pushes accepted, fill level tracked, flush command accepted
// FLUSH | DEPTH zero-shifts in progress, pushes dropped, flush ignored
module mmio_fifo_ctrl
  import mmio_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 16,
  parameter logic [ADDR_W-1:0] DATA_ADDR = ADDR_W'(MMIO_DATA_ADDR),
  parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(MMIO_STAT_ADDR),
  parameter logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(MMIO_CTRL_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [8:0]        rd_tid,
  output logic              resp_valid,
  output logic [8:0]        resp_tid,
  output logic [DATA_W-1:0] resp_data,
  output logic              fifo_en,
  output logic [DATA_W-1:0] fifo_d,
  input  logic [DATA_W-1:0] fifo_q
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned FL_W  = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  t_fifo_ctrl_state  state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              ovwr_q, ovwr_d;
  logic              drop_q, drop_d;
  logic              fifo_en_q, fifo_en_d;
  logic [DATA_W-1:0] fifo_d_q, fifo_d_d;
  logic              resp_valid_q, resp_valid_d;
  logic [8:0]        resp_tid_q, resp_tid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic              wr_data_hit;
  logic              wr_ctrl_hit;
  logic [15:0]       stat_word;

  assign wr_data_hit = wr_valid && (wr_addr == DATA_ADDR);
  assign wr_ctrl_hit = wr_valid && (wr_addr == CTRL_ADDR);

  always_comb begin
    stat_word                              = '0;
    stat_word[STAT_CNT_LSB +: 8]           = 8'(count_q);
    stat_word[STAT_OVWR_BIT]               = ovwr_q;
    stat_word[STAT_DROP_BIT]               = drop_q;
    stat_word[STAT_FLUSHING_BIT]           = (state_q == FLUSH);
    stat_word[STAT_FULL_BIT]               = (count_q == DEPTH_CNT);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    flush_cnt_d = flush_cnt_q;
    ovwr_d      = ovwr_q;
    drop_d      = drop_q;
    fifo_en_d   = 1'b0;
    fifo_d_d    = '0;

    case (state_q)
      IDLE: begin
        if (wr_data_hit) begin
          fifo_en_d = 1'b1;
          fifo_d_d  = wr_data;
          // A push into a full shift register pushes the oldest entry out.
          if (count_q == DEPTH_CNT) ovwr_d = 1'b1;
          else                      count_d = count_q + CNT_W'(1);
        end else if (wr_ctrl_hit && wr_data[FLUSH_BIT]) begin
          state_d     = FLUSH;
          flush_cnt_d = FL_W'(DEPTH - 1);
          fifo_en_d   = 1'b1;
        end
      end
      FLUSH: begin
        if (wr_data_hit) drop_d = 1'b1;
        if (flush_cnt_q == '0) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FL_W'(1);
          fifo_en_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_ctrl_hit && wr_data[CLR_BIT]) begin
      ovwr_d = 1'b0;
      drop_d = 1'b0;
    end
  end

  always_comb begin
    resp_valid_d = rd_valid;
    resp_tid_d   = '0;
    resp_data_d  = '0;
    if (rd_valid) begin
      resp_tid_d = rd_tid;
      if (rd_addr == DATA_ADDR)      resp_data_d = fifo_q;
      else if (rd_addr == STAT_ADDR) resp_data_d = DATA_W'(stat_word);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      flush_cnt_q  <= '0;
      ovwr_q       <= 1'b0;
      drop_q       <= 1'b0;
      fifo_en_q    <= 1'b0;
      fifo_d_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_tid_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      flush_cnt_q  <= flush_cnt_d;
      ovwr_q       <= ovwr_d;
      drop_q       <= drop_d;
      fifo_en_q    <= fifo_en_d;
      fifo_d_q     <= fifo_d_d;
      resp_valid_q <= resp_valid_d;
      resp_tid_q   <= resp_tid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_tid   = resp_tid_q;
  assign resp_data  = resp_data_q;
  assign fifo_en    = fifo_en_q;
  assign fifo_d     = fifo_d_q;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Scoreboard bench for mmio_fifo_ctrl with a behavioural shift-register FIFO
// standing in for the one the parent AFU instantiates.
module tb_mmio_fifo_ctrl;
  import mmio_fifo_ctrl_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [8:0]        rd_tid = '0;
  logic              resp_valid;
  logic [8:0]        resp_tid;
  logic [DATA_W-1:0] resp_data;
  logic              fifo_en;
  logic [DATA_W-1:0] fifo_d;
  logic [DATA_W-1:0] fifo_q;

  logic [DATA_W-1:0] stg [DEPTH];

  typedef struct {
    string       tag;
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } t_exp;

  t_exp exp_q[$];
  t_exp mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   zero_en_cnt = 0;

  always #5 clk = ~clk;

  mmio_fifo_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_tid     (rd_tid),
    .resp_valid (resp_valid),
    .resp_tid   (resp_tid),
    .resp_data  (resp_data),
    .fifo_en    (fifo_en),
    .fifo_d     (fifo_d),
    .fifo_q     (fifo_q)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else if (fifo_en) begin
      stg[0] <= fifo_d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end
  assign fifo_q = stg[DEPTH-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  always @(negedge clk) begin
    if (fifo_en) begin
      en_cnt++;
      if (fifo_d == '0) zero_en_cnt++;
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.tag, "_tid"},  64'(resp_tid), 64'(mon_e.tid));
        check({mon_e.tag, "_data"}, resp_data, mon_e.data);
        check({mon_e.tag, "_lat"},  64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic bus(input logic w, input logic [15:0] wa, input logic [63:0] wd,
                     input logic r, input logic [15:0] ra, input logic [8:0] tid,
                     input logic [63:0] ed, input string tag);
    wr_valid = w;
    wr_addr  = wa;
    wr_data  = wd;
    rd_valid = r;
    rd_addr  = ra;
    rd_tid   = tid;
    if (r) exp_q.push_back('{tag: tag, tid: tid, data: ed, due: cyc + 1});
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    bus(1'b1, a, d, 1'b0, 16'h0, 9'h0, 64'h0, "");
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] tid, input logic [63:0] e,
                    input string tag);
    bus(1'b0, 16'h0, 64'h0, 1'b1, a, tid, e, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_tid",   64'(resp_tid),   64'd0);
    check("rst_resp_data",  resp_data,       64'd0);
    check("rst_fifo_en",    64'(fifo_en),    64'd0);
    check("rst_fifo_d",     fifo_d,          64'd0);
    rd(MMIO_STAT_ADDR, 9'h001, 64'h0, "rst_stat");

    // Fill to DEPTH with 0x11..0x88
    en_cnt = 0;
    for (int i = 1; i <= DEPTH; i++) wr(MMIO_DATA_ADDR, 64'(i * 'h11));
    idle(2);
    check("fill_en_pulses", 64'(en_cnt), 64'd8);
    rd(MMIO_STAT_ADDR, 9'h002, 64'h0801, "full_stat");

    wr(MMIO_DATA_ADDR, 64'h99);
    idle(2);
    check("ovwr_en_pulses", 64'(en_cnt), 64'd9);
    rd(MMIO_STAT_ADDR, 9'h003, 64'h0809, "ovwr_stat");
    rd(MMIO_DATA_ADDR, 9'h004, 64'h22,   "ovwr_data");

    // Flush; push during flush is dropped
    idle(1);
    en_cnt = 0;
    zero_en_cnt = 0;
    wr(MMIO_CTRL_ADDR, 64'h1);
    idle(2);
    rd(MMIO_STAT_ADDR, 9'h005, 64'h080B, "flush_mid_stat");
    wr(MMIO_DATA_ADDR, 64'hAB);
    wr(MMIO_CTRL_ADDR, 64'h1);
    idle(DEPTH);
    check("flush_en_pulses", 64'(en_cnt),      64'd8);
    check("flush_zero_d",    64'(zero_en_cnt), 64'd8);
    rd(MMIO_STAT_ADDR, 9'h006, 64'h000C, "post_flush_stat");
    rd(MMIO_DATA_ADDR, 9'h007, 64'h0,    "post_flush_data");

    en_cnt = 0;
    wr(MMIO_CTRL_ADDR, 64'h2);
    rd(MMIO_STAT_ADDR, 9'h008, 64'h0, "clr_stat");
    idle(1);
    check("clr_no_en", 64'(en_cnt), 64'd0);

    // Refill; concurrent read/write sees pre-update state
    for (int i = 1; i < DEPTH; i++) wr(MMIO_DATA_ADDR, 64'(i));
    bus(1'b1, MMIO_DATA_ADDR, 64'h8, 1'b1, MMIO_STAT_ADDR, 9'h011, 64'h0700, "rw_stat");
    rd(MMIO_STAT_ADDR, 9'h012, 64'h0801, "rw_stat_after");
    idle(1);
    bus(1'b1, MMIO_DATA_ADDR, 64'h9, 1'b1, MMIO_DATA_ADDR, 9'h1A3, 64'h1, "rw_data");
    rd(MMIO_DATA_ADDR, 9'h0A0, 64'h1, "data_plus1");
    rd(MMIO_DATA_ADDR, 9'h0A1, 64'h2, "data_plus2");
    rd(16'h0030,       9'h055, 64'h0, "unmapped_rd");
    rd(MMIO_CTRL_ADDR, 9'h056, 64'h0, "ctrl_rd");
    en_cnt = 0;
    wr(16'h0030, 64'hDEAD);
    wr(MMIO_STAT_ADDR, 64'hFF);
    idle(1);
    check("unmapped_no_en", 64'(en_cnt), 64'd0);
    rd(MMIO_STAT_ADDR, 9'h057, 64'h0809, "unmapped_stat");

    // Flush+clear together, then reset in cycle 4 of the flush
    wr(MMIO_CTRL_ADDR, 64'h3);
    idle(2);
    rd(MMIO_STAT_ADDR, 9'h077, 64'h0803, "flushclr_stat");
    check("pre_rst_fifo_en", 64'(fifo_en), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_fifo_en",    64'(fifo_en),    64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_fifo_d",     fifo_d,          64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    en_cnt = 0;
    idle(2);
    rd(MMIO_STAT_ADDR, 9'h078, 64'h0, "post_rst_stat");
    idle(DEPTH);
    check("post_rst_no_en", 64'(en_cnt), 64'd0);

    idle(2);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_ctrl.md
Name: mmio_fifo_ctrl

Overview:
Sequencing controller between the AFU's MMIO decode and the DEPTH-stage shift-register FIFO (single enable, data in, oldest-stage out).
- Turns MMIO writes into FIFO pushes and tracks fill level.
- Runs a multi-cycle flush sequence on command.
- Produces single-cycle MMIO read responses for the data, status and control registers.
- The parent AFU instantiates the FIFO and handles the DFH/AFU_ID addresses.

Parameters:
DEPTH, 8, number of FIFO shift stages (>=2)
DATA_W, 64, data width
ADDR_W, 16, MMIO address width
DATA_ADDR, 16'h0020, push on write / FIFO oldest-stage on read
STAT_ADDR, 16'h0022, status register (read-only)
CTRL_ADDR, 16'h0024, control register (write-only; reads return 0)

Ports:
clk  in  1  clock
rst  in  1  reset
wr_valid  in  1  MMIO write strobe
wr_addr  in  ADDR_W  MMIO write address
wr_data  in  DATA_W  MMIO write data
rd_valid  in  1  MMIO read strobe
rd_addr  in  ADDR_W  MMIO read address
rd_tid  in  9  read transaction ID
resp_valid  out  1  read response strobe
resp_tid  out  9  echoed rd_tid
resp_data  out  DATA_W  read response data
fifo_en  out  1  FIFO shift enable
fifo_d  out  DATA_W  FIFO input data
fifo_q  in  DATA_W  FIFO oldest-stage output

Behaviour:
- Reset and clock: rst is asynchronous, active-high; clk is the clock.
- Reset values: resp_valid=0, resp_tid=0, resp_data=0, fifo_en=0, fifo_d=0, count=0, state=IDLE, all sticky bits 0. All outputs are registered.
- States:
  - IDLE -> FLUSH on a CTRL write with bit0=1.
  - FLUSH -> IDLE after exactly DEPTH enable cycles.
  - No other states.
- Push (IDLE, wr_valid && wr_addr==DATA_ADDR):
  - Next cycle: fifo_en=1, fifo_d=wr_data.
  - count increments at the accepting edge, saturating at DEPTH.
  - If count==DEPTH before the push, the oldest entry is lost and sticky OVWR is set.
- Push during FLUSH: dropped, no fifo_en, sticky DROP set.
- Flush:
  - fifo_en=1 and fifo_d=0 for DEPTH consecutive cycles, starting the cycle after the CTRL write.
  - flush counter is log2(DEPTH)+1 bits.
  - count becomes 0 on the edge that ends FLUSH.
  - A CTRL flush write during FLUSH is ignored; the flush is not restarted.
- Sticky clear: CTRL write with bit1=1 clears OVWR and DROP in any state.
  - If bit0 and bit1 are set together, clear and flush both happen.
- fifo_en deasserts the cycle after the last push or flush step; no spurious enables.
- Read response:
  - Any rd_valid produces resp_valid=1 for exactly one cycle, 1 cycle later, with resp_tid=rd_tid.
  - resp_data: DATA_ADDR -> fifo_q sampled in the request cycle.
  - STAT_ADDR -> {zeros, count[7:0] at [15:8], OVWR[3], DROP[2], FLUSHING[1], FULL[0]}, where FULL = (count==DEPTH).
  - Any other address -> 0.
  - Reads are serviced in every state, including FLUSH.
- Simultaneous read and write in the same cycle: the read sees pre-update count, stickies and fifo_q.
- Visibility of writes:
  - STAT reads issued 1 or more cycles after a write see the updated count.
  - DATA reads see a pushed value at fifo_q only from 2 cycles after the write, once the shift has occurred.
- Writes to unmapped addresses: no effect.
- Reset mid-flush returns immediately to IDLE with count=0 and fifo_en=0. The FIFO itself is reset by the parent.

Decomposition:
- Package mmio_fifo_ctrl_pkg holds:
  - the address constants;
  - the state enum t_fifo_ctrl_state {IDLE, FLUSH};
  - the status bit-position localparams;
  - the CTRL bit positions (FLUSH_BIT=0, CLR_BIT=1).
- No sub-module: the FSM, the count/flush counters and the response register fit in one module.
- The FIFO is instantiated alongside by the parent AFU, not inside this block.

Test Plan:
- Reset, then write 0x11..0x88 to 0x0020 on 8 consecutive cycles -> 8 fifo_en pulses; STAT read returns count=8, FULL=1, OVWR=0.
- Ninth write 0x99 -> OVWR=1, count stays 8; DATA read returns 0x22 (0x11 shifted out).
- Write 0x1 to 0x0024 -> fifo_en high with fifo_d=0 for exactly 8 cycles; STAT read mid-flush shows FLUSHING=1; afterwards count=0 and DATA read returns 0.
- DATA write issued during FLUSH -> no extra fifo_en, DROP=1; then write 0x2 to CTRL -> DROP=0 and OVWR=0.
- Read of 0x0020 with tid=0x1A3 in the same cycle as a DATA write -> resp_valid one cycle later with tid=0x1A3 and pre-write data; read of 0x0030 -> resp_data=0.
- Assert rst during cycle 4 of a flush -> fifo_en=0 and resp_valid=0 immediately; STAT read after release returns 0.
